// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and the period of an asynchronous PWM
// line between consecutive rising edges and reports them with a one-cycle
// valid strobe. It flags a stuck line when no rising edge arrives before the
// period counter runs out.
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             a_reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [WIDTH:0]   PERIOD_MAX = '1;
  localparam logic [WIDTH-1:0] HIGH_MAX   = '1;
  localparam logic [WIDTH:0]   PERIOD_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] HIGH_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic s1, s2, s3;
  logic rise;
  state_t state_q, state_d;
  logic [WIDTH:0]   period_cnt;
  logic [WIDTH-1:0] high_cnt;
  logic start, capture, timeout, count;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign level = s2;

  // State register.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first rise starts measuring, a timeout falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: if (!rise && period_cnt == PERIOD_MAX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode per-cycle actions from the current state and the edge detector.
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    count   = 1'b0;
    case (state_q)
      IDLE: begin
        start = rise;
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
        end else if (period_cnt == PERIOD_MAX) begin
          timeout = 1'b1;
        end else begin
          count = 1'b1;
        end
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  // Period and high-time counters; the edge cycle is the first cycle of a period.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (start || capture) begin
      period_cnt <= PERIOD_ONE;
      high_cnt   <= HIGH_ONE;
    end else if (count) begin
      period_cnt <= period_cnt + PERIOD_ONE;
      if (s2 && high_cnt != HIGH_MAX) begin
        high_cnt <= high_cnt + HIGH_ONE;
      end
    end
  end

  // Result registers: publish on a completed period, report the line level on timeout.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        duty   <= high_cnt;
        period <= period_cnt;
        stuck  <= 1'b0;
      end else if (timeout) begin
        duty   <= s2 ? HIGH_MAX : '0;
        period <= '0;
        stuck  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with a scoreboard of expected
// duty/period results checked by an independent monitor on every valid.
module tb_pwm_capture;

  localparam int WIDTH = 8;

  logic             clk;
  logic             a_reset;
  logic             pwm_in;
  logic [WIDTH-1:0] duty;
  logic [WIDTH:0]   period;
  logic             valid;
  logic             stuck;
  logic             level;

  typedef struct {
    int duty;
    int period;
    int stuck;
  } result_t;

  result_t sb[$];
  int total = 0;
  int bad = 0;
  int have_prev = 0;
  int prev_h = 0;
  int prev_p = 0;

  pwm_capture #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .a_reset(a_reset),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck),
    .level  (level)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full PWM period: high h cycles then low p-h cycles, starting with a rise.
  // The rise that opens this period reports the previous one.
  task automatic apply_stimulus(input int h, input int p);
    result_t r;
    if (have_prev != 0) begin
      r.duty   = (prev_h > 255) ? 255 : prev_h;
      r.period = prev_p;
      r.stuck  = 0;
      sb.push_back(r);
    end
    pwm_in = 1'b1;
    repeat (h) begin
      @(posedge clk);
      #2;
    end
    pwm_in = 1'b0;
    repeat (p - h) begin
      @(posedge clk);
      #2;
    end
    prev_h    = h;
    prev_p    = p;
    have_prev = 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_valid", 1, 0);
      end else begin
        result_t e;
        e = sb.pop_front();
        check_output("duty", int'(duty), e.duty);
        check_output("period", int'(period), e.period);
        check_output("stuck_on_valid", int'(stuck), e.stuck);
      end
    end
  end

  initial begin
    int waited;
    pwm_in  = 1'b0;
    a_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_duty", int'(duty), 0);
    check_output("reset_period", int'(period), 0);
    check_output("reset_valid", int'(valid), 0);
    check_output("reset_stuck", int'(stuck), 0);
    check_output("reset_level", int'(level), 0);
    #1;
    a_reset = 1'b1;
    @(posedge clk);
    #2;

    // Idle line after reset: no measurement, no timeout.
    idle_cycles(600);
    check_output("idle_stuck", int'(stuck), 0);
    check_output("idle_queue", sb.size(), 0);

    // Generator-style 256/64.
    repeat (4) apply_stimulus(64, 256);
    // Narrow pulse and minimum period.
    repeat (3) apply_stimulus(1, 10);
    repeat (3) apply_stimulus(1, 2);
    // High time change at a period boundary.
    repeat (2) apply_stimulus(64, 256);
    repeat (2) apply_stimulus(200, 256);

    // One rise reporting the last period, then a dead-low line.
    begin
      result_t r;
      r.duty = prev_h; r.period = prev_p; r.stuck = 0;
      sb.push_back(r);
    end
    have_prev = 0;
    pwm_in = 1'b1;
    idle_cycles(2);
    pwm_in = 1'b0;
    waited = 0;
    while (stuck !== 1'b1 && waited < 700) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_output("low_stuck", int'(stuck), 1);
    check_output("low_duty", int'(duty), 0);
    check_output("low_period", int'(period), 0);
    check_output("low_level", int'(level), 0);

    // Rise then a line held high.
    @(posedge clk);
    #2;
    pwm_in = 1'b1;
    waited = 0;
    while (duty !== 8'hFF && waited < 700) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_output("high_stuck", int'(stuck), 1);
    check_output("high_duty", int'(duty), 255);
    check_output("high_period", int'(period), 0);
    check_output("high_level", int'(level), 1);

    // Saturating high time, then recovery.
    @(posedge clk);
    #2;
    pwm_in = 1'b0;
    idle_cycles(5);
    repeat (2) apply_stimulus(300, 400);
    repeat (2) apply_stimulus(128, 256);

    // Reset in the middle of a high phase (high count around 37).
    begin
      result_t r;
      r.duty = prev_h; r.period = prev_p; r.stuck = 0;
      sb.push_back(r);
    end
    have_prev = 0;
    pwm_in = 1'b1;
    idle_cycles(39);
    check_output("pending_before_reset", sb.size(), 0);
    a_reset = 1'b0;
    #1;
    check_output("midreset_duty", int'(duty), 0);
    check_output("midreset_period", int'(period), 0);
    check_output("midreset_valid", int'(valid), 0);
    check_output("midreset_stuck", int'(stuck), 0);
    check_output("midreset_level", int'(level), 0);
    pwm_in = 1'b0;
    idle_cycles(2);
    a_reset = 1'b1;
    idle_cycles(3);
    repeat (2) apply_stimulus(64, 256);
    repeat (2) apply_stimulus(200, 256);
    apply_stimulus(1, 4);
    idle_cycles(10);
    check_output("final_queue", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the team's counter-based PWM generator. Samples an asynchronous PWM input, measures the high time and the period between consecutive rising edges, and publishes them with a one-cycle valid strobe. Detects a stuck line (0 % or 100 % duty, or a disconnected source) by timeout. Sits in the same single clock domain as the generator. Used for loopback self-test and to read external PWM sources.

Parameters:
WIDTH, 8, width of the duty result. The period result and internal period counter are WIDTH+1 bits.

Ports:
clk  input  1  system clock
a_reset  input  1  asynchronous active-low reset
pwm_in  input  1  PWM line, asynchronous to clk
duty  output  WIDTH  high-time of the last complete period in clk cycles, saturating
period  output  WIDTH+1  length of the last complete period in clk cycles
valid  output  1  one-cycle strobe, duty/period just updated
stuck  output  1  no rising edge within the timeout window
level  output  1  synchronized pwm_in level

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (a_reset). Async assert, release on clk.
  - On assertion, every flop clears: sync stages, edge-history flop, counters, FSM state (IDLE), and outputs duty=0, period=0, valid=0, stuck=0, level=0.
  - Asserting reset mid-measurement discards the partial period.
- Input sampling:
  - 2-flop synchronizer s1→s2, then a history flop s3; level=s2.
  - rise = s2 & ~s3.
  - A pwm_in transition reaches s2 two clk edges after it is sampled.
- FSM states: IDLE, MEASURE.
  - IDLE: counters held. On rise → MEASURE, period_cnt=1, high_cnt=1.
  - MEASURE, each cycle without rise: period_cnt+=1; if s2=1, high_cnt+=1. high_cnt saturates at 2^WIDTH-1.
  - MEASURE with rise: duty<=high_cnt, period<=period_cnt, valid<=1 (next edge, single cycle), stuck<=0. Counters restart at 1, so the edge cycle is the first cycle of the new period. Stay in MEASURE.
  - Timeout: period_cnt reaches 2^(WIDTH+1)-1 with no rise → stuck<=1, period<=0, and duty<=all-ones if s2=1 else 0. Go to IDLE. No valid pulse.
  - stuck stays set until the next full measurement completes (two rises after leaving IDLE).
- Result semantics: a waveform high H cycles within period P (P ≤ 2^(WIDTH+1)-2) gives duty=min(H, 2^WIDTH-1) and period=P.
- Latency: valid asserts on the 3rd clk edge after the edge that first samples pwm_in high. The first valid occurs only after the second rise following reset or timeout.
- Glitches: a high pulse shorter than one clk may be missed. No filtering is done.
- duty, period and stuck hold their values between updates.

Test Plan:
- Generator-style input, period 256, high 64, repeated → after the 2nd rise, valid every 256 cycles with duty=64, period=256, stuck=0.
- Period 10, high 1 cycle → duty=1, period=10. Period 2, high 1 → duty=1, period=2 (minimum period).
- pwm_in held 0 after reset → no valid. After the first rise then constant 0: once period_cnt reaches 511, stuck=1, duty=0, period=0. Constant 1 after a rise gives stuck=1, duty=255.
- Period 400, high 300 → duty=255 (saturated), period=400. Then restore period 256 / high 128 → stuck clears and duty=128 on the second valid.
- Reset asserted mid-period with high_cnt=37 → all outputs 0 immediately. After release, the first valid appears only after two further rises, with correct values.
- Change the high time from 64 to 200 at a period boundary → the next valid shows duty=200. No intermediate mixed value appears.
